// File: rtl/ntt_drain_pkg.sv
// Shared types for the NTT result drain: word layout, FSM states, lane math.
// The drain's optional counters are enabled with NTT_OUTPUT_DRAIN_STATS_EN.
package ntt_drain_pkg;

  localparam int COEF_W = 30;
  localparam int WORD_W = 2 * COEF_W;

  typedef logic [WORD_W-1:0] ntt_word_t;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DRAIN
  } drain_state_t;

  function automatic int lanes(input int log_core_count);
    return 2 << log_core_count;
  endfunction

endpackage

// File: rtl/ntt_drain_row_serializer.sv
// Turns one buffered result row into a valid/ready word stream.
// A new row is taken on the same edge the previous row's final word leaves.
module ntt_drain_row_serializer
  import ntt_drain_pkg::*;
#(
  parameter int LANES = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [LANES*WORD_W-1:0] row_data,
  input  logic                    row_valid,
  input  logic                    row_last,
  output logic                    row_take,
  output ntt_word_t               m_data,
  output logic                    m_valid,
  output logic                    m_last,
  input  logic                    m_ready
);

  localparam int LW = $clog2(LANES);

  logic [LANES*WORD_W-1:0] row_q;
  logic                    last_q;
  logic                    valid_q;
  logic [LW-1:0]           lane_q;
  logic                    lane_end;
  logic                    accept;

  assign lane_end = (lane_q == LW'(LANES - 1));
  assign accept   = valid_q & m_ready;
  assign row_take = row_valid & (~valid_q | (accept & lane_end));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q   <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      lane_q  <= '0;
    end else if (row_take) begin
      row_q   <= row_data;
      last_q  <= row_last;
      valid_q <= 1'b1;
      lane_q  <= '0;
    end else if (accept) begin
      if (lane_end) valid_q <= 1'b0;
      else          lane_q  <= lane_q + 1'b1;
    end
  end

  assign m_data  = row_q[lane_q*WORD_W +: WORD_W];
  assign m_valid = valid_q;
  assign m_last  = valid_q & last_q & lane_end;

endmodule

// File: rtl/ntt_output_drain.sv
// Captures a full ntt_processor result frame, then drains it as 60-bit words.
// Define NTT_OUTPUT_DRAIN_STATS_EN to add frames_done and drop_cnt outputs.
module ntt_output_drain
  import ntt_drain_pkg::*;
#(
  parameter int LOG_CORE_COUNT  = 4,
  parameter int LOG_FRAME_BEATS = 6,
  parameter int ADDR_OUT_W      = 9
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       output_active,
  input  ntt_word_t [(1<<LOG_CORE_COUNT)-1:0][1:0]   out,
  input  logic [ADDR_OUT_W-1:0]                      address_out,
  output ntt_word_t                                  m_data,
  output logic                                       m_valid,
  input  logic                                       m_ready,
  output logic                                       m_last,
  output logic                                       busy,
  output logic                                       overflow
`ifdef NTT_OUTPUT_DRAIN_STATS_EN
  ,
  output logic [15:0]                                frames_done,
  output logic [15:0]                                drop_cnt
`endif
);

  localparam int LANES = lanes(LOG_CORE_COUNT);
  localparam int BEATS = 1 << LOG_FRAME_BEATS;
  localparam int ROW_W = LANES * WORD_W;
  localparam int CW    = LOG_FRAME_BEATS + 1;

  drain_state_t         state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d, cnt_inc;
  logic                 wr_en, drop, last_acc, drain;
  logic [ROW_W-1:0]     beat_row;
  logic [LOG_FRAME_BEATS-1:0] wr_row;

  logic [ROW_W-1:0]     mem [BEATS];
  logic [ROW_W-1:0]     rd_data_q;
  logic [CW-1:0]        rd_row_q;
  logic                 pf_valid_q, pf_last_q;
  logic                 rd_issue, row_take;

  assign beat_row = out;
  assign wr_row   = address_out[LOG_FRAME_BEATS-1:0];
  assign drain    = (state_q == DRAIN);
  assign busy     = (state_q != IDLE);
  assign last_acc = m_last & m_ready;

  generate
    if (ADDR_OUT_W > LOG_FRAME_BEATS) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^address_out[ADDR_OUT_W-1:LOG_FRAME_BEATS];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    drop    = 1'b0;
    cnt_inc = (state_q == IDLE) ? CW'(1) : cnt_q + 1'b1;
    unique case (state_q)
      IDLE, CAPTURE: begin
        if (output_active) begin
          wr_en   = 1'b1;
          cnt_d   = cnt_inc;
          state_d = (cnt_inc == CW'(BEATS)) ? DRAIN : CAPTURE;
        end
      end
      DRAIN: begin
        drop = output_active;
        if (last_acc) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Row fetch runs one row ahead of the serializer so rows chain seamlessly.
  assign rd_issue = drain & (rd_row_q != CW'(BEATS))
                  & (~pf_valid_q | row_take);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_row_q   <= '0;
      pf_valid_q <= 1'b0;
      pf_last_q  <= 1'b0;
    end else if (!drain) begin
      rd_row_q   <= '0;
      pf_valid_q <= 1'b0;
      pf_last_q  <= 1'b0;
    end else if (rd_issue) begin
      rd_row_q   <= rd_row_q + 1'b1;
      pf_valid_q <= 1'b1;
      pf_last_q  <= (rd_row_q == CW'(BEATS - 1));
    end else if (row_take) begin
      pf_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)    mem[wr_row] <= beat_row;
    if (rd_issue) rd_data_q   <= mem[rd_row_q[LOG_FRAME_BEATS-1:0]];
  end

  ntt_drain_row_serializer #(
    .LANES (LANES)
  ) u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_data  (rd_data_q),
    .row_valid (pf_valid_q),
    .row_last  (pf_last_q),
    .row_take  (row_take),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_last    (m_last),
    .m_ready   (m_ready)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
  end

`ifdef NTT_OUTPUT_DRAIN_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frames_done <= '0;
      drop_cnt    <= '0;
    end else begin
      if (last_acc) frames_done <= frames_done + 1'b1;
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ntt_output_drain.sv
// Randomized frame/backpressure bench for ntt_output_drain against a queue model.
module tb_ntt_output_drain;
  import ntt_drain_pkg::*;

  localparam int BEATS = 64;
  localparam int LANES = 32;
  localparam int WORDS = BEATS * LANES;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic output_active = 1'b0;
  logic m_ready = 1'b0;
  logic [15:0][1:0][59:0] out_bus;
  logic [8:0] address_out;
  logic [59:0] m_data;
  logic m_valid, m_last, busy, overflow;
`ifdef NTT_OUTPUT_DRAIN_STATS_EN
  logic [15:0] frames_done, drop_cnt;
`endif

  always #5 clk = ~clk;

  ntt_output_drain dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .output_active (output_active),
    .out           (out_bus),
    .address_out   (address_out),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_last        (m_last),
    .busy          (busy),
    .overflow      (overflow)
`ifdef NTT_OUTPUT_DRAIN_STATS_EN
    ,
    .frames_done   (frames_done),
    .drop_cnt      (drop_cnt)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  // Reference model: rows as an array, the expected word stream as a queue.
  logic [59:0] mrows [BEATS][LANES];
  logic [59:0] exp_q [$];
  int  mcnt, age, mframes, mdrops, acc_cnt;
  bit  draining, movf, strict;
  bit  prev_stall;
  logic [59:0] prev_data;
  logic prev_last;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      mcnt = 0; age = 0; mframes = 0; mdrops = 0; acc_cnt = 0;
      draining = 0; movf = 0; prev_stall = 0;
    end else begin
      if (draining) age++;
      chk("busy", busy, (mcnt != 0) || draining);
      chk("overflow", overflow, movf);
`ifdef NTT_OUTPUT_DRAIN_STATS_EN
      chk("frames_done", frames_done, 16'(mframes));
      chk("drop_cnt", drop_cnt, 16'(mdrops));
`endif
      if (output_active) begin
        if (draining) begin
          movf = 1;
          if (mdrops < 65535) mdrops++;
        end else begin
          for (int c = 0; c < 16; c++)
            for (int w = 0; w < 2; w++)
              mrows[address_out[5:0]][c*2+w] = out_bus[c][w];
          mcnt++;
          if (mcnt == BEATS) begin
            mcnt = 0; draining = 1; age = 0; acc_cnt = 0;
            for (int r = 0; r < BEATS; r++)
              for (int l = 0; l < LANES; l++)
                exp_q.push_back(mrows[r][l]);
          end
        end
      end
      if (strict) chk("m_valid", m_valid, draining && age >= 3);
      else if (m_valid) chk("early_valid", draining && age >= 3, 1);
      if (prev_stall)
        chk("stall_hold", {m_valid, m_last, m_data},
            {1'b1, prev_last, prev_data});
      if (m_valid) begin
        if (exp_q.size() == 0) chk("spurious_word", m_valid, 0);
        else begin
          chk("m_data", m_data, exp_q[0]);
          chk("m_last", m_last, exp_q.size() == 1);
          if (m_ready) begin
            void'(exp_q.pop_front());
            acc_cnt++;
            if (exp_q.size() == 0) begin
              draining = 0;
              mframes++;
            end
          end
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  int ready_mode = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // order: 0 ascending, 1 descending, 2 random permutation
  task automatic apply_frame(input int order, input bit gaps, input bit rnd);
    int perm [BEATS];
    int j, tmp, b;
    logic [63:0] r64;
    for (int i = 0; i < BEATS; i++) perm[i] = (order == 1) ? BEATS-1-i : i;
    if (order == 2)
      for (int i = BEATS-1; i > 0; i--) begin
        j = $urandom_range(0, i);
        tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
      end
    for (int i = 0; i < BEATS; i++) begin
      if (gaps && (i % 5 == 4)) begin
        output_active = 0;
        step();
      end
      b = perm[i];
      output_active = 1;
      address_out = {3'($urandom_range(0, 7)), 6'(b)};
      for (int c = 0; c < 16; c++)
        for (int w = 0; w < 2; w++)
          if (rnd) begin
            r64 = {$urandom(), $urandom()};
            out_bus[c][w] = r64[59:0];
          end else out_bus[c][w] = 60'(b*32 + c*2 + w);
      step();
    end
    output_active = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 20000) begin
      step();
      n++;
    end
    chk("drain_timeout", n < 20000, 1);
    step();
  endtask

  initial begin
    int n, bub, t;
    fork
      forever begin
        @(posedge clk);
        #1;
        m_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      end
    join_none

    out_bus = '0;
    address_out = '0;
    #12;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    step();
    rst_n = 1;
    strict = 1;
    step();

    // in-order frame, m_ready high: latency, bubbles, final word
    apply_frame(0, 0, 0);
    @(negedge clk); chk("lat_edge1", m_valid, 0);
    @(negedge clk); chk("lat_edge2", m_valid, 0);
    @(negedge clk); chk("lat_edge3", m_valid, 1);
    chk("first_word", m_data, 0);
    n = 1; bub = 0; t = 0;
    while (!m_last && t < 4000) begin
      @(negedge clk);
      t++;
      if (m_valid) n++;
      else bub++;
    end
    chk("word_count", n, WORDS);
    chk("bubbles", bub, 0);
    chk("last_word", m_data, 60'd2047);
    @(negedge clk);
    chk("busy_after", busy, 0);
    chk("valid_after", m_valid, 0);
    step();

    // reverse address order, same data
    apply_frame(1, 0, 0);
    wait_idle();

    // random data, shuffled addresses, random backpressure
    ready_mode = 1;
    strict = 0;
    apply_frame(2, 0, 1);
    wait_idle();

    // beats arriving during drain
    ready_mode = 0;
    strict = 1;
    apply_frame(0, 0, 0);
    repeat (5) step();
    output_active = 1;
    repeat (3) step();
    output_active = 0;
    step();
    chk("overflow_set", overflow, 1);
`ifdef NTT_OUTPUT_DRAIN_STATS_EN
    chk("drop_cnt_3", drop_cnt, 16'd3);
`endif
    wait_idle();
    chk("overflow_sticky", overflow, 1);

    // gapped capture
    apply_frame(0, 1, 0);
    wait_idle();

    // reset during drain after 100 words
    apply_frame(0, 0, 1);
    t = 0;
    while (acc_cnt < 100 && t < 5000) begin
      step();
      t++;
    end
    chk("acc100_timeout", t < 5000, 1);
    rst_n = 0;
    #1;
    chk("rstmid_m_valid", m_valid, 0);
    chk("rstmid_overflow", overflow, 0);
    chk("rstmid_busy", busy, 0);
    step();
    step();
    rst_n = 1;
    step();
    apply_frame(0, 0, 0);
    wait_idle();
`ifdef NTT_OUTPUT_DRAIN_STATS_EN
    chk("frames_after_rst", frames_done, 16'd1);
    chk("drops_after_rst", drop_cnt, 16'd0);
`endif
    chk("overflow_after_rst", overflow, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors,
             miscompares);
    $finish;
  end

endmodule

// File: doc/ntt_output_drain.md
Name: ntt_output_drain

Overview:
- Sink for the ntt_processor result interface (`output_active`, `out[core][word]`, `address_out`).
- Captures one full result frame of wide parallel beats into local storage, then drains it as a 60-bit valid/ready word stream for host readback/DMA.
- Sits directly after ntt_processor. It is the consumer of the interface the processor drives, and it exists because the processor has no backpressure.

Parameters:
- LOG_CORE_COUNT, 4, log2 of butterfly cores. LANES = 2 << LOG_CORE_COUNT words per beat.
- LOG_FRAME_BEATS, 6, log2 of beats per frame (64 beats x 32 words = 2048 words = 4096 coefficients).
- ADDR_OUT_W, 9, width of the processor's `address_out`.

Ports:
- clk  in  1  single clock; rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- output_active  in  1  processor beat valid.
- out  in  [59:0] x [2^LOG_CORE_COUNT][2]  beat data; word = {coef_hi[59:30], coef_lo[29:0]}.
- address_out  in  ADDR_OUT_W  beat index; only bits [LOG_FRAME_BEATS-1:0] are used.
- m_data  out  60  serialized word.
- m_valid  out  1  m_data valid.
- m_ready  in  1  consumer accepts when m_valid and m_ready are both high.
- m_last  out  1  high on the final word of a frame.
- busy  out  1  high in CAPTURE or DRAIN.
- overflow  out  1  sticky; a beat arrived while in DRAIN.

Behaviour:
- Reset: one clock, `clk`; asynchronous active-low `rst_n`. With rst_n low, all outputs are 0, state = IDLE, counters = 0, and overflow is cleared. Storage contents are don't-care.
- State IDLE:
  - output_active=1: store the beat at row address_out[LOG_FRAME_BEATS-1:0], beat_cnt=1, go to CAPTURE.
- State CAPTURE:
  - Each output_active=1 cycle stores one beat at its address_out row and increments beat_cnt.
  - When the stored beat makes beat_cnt = 2^LOG_FRAME_BEATS, go to DRAIN on that edge.
  - Gaps in output_active are allowed.
  - A repeated address overwrites the row but still counts toward beat_cnt.
- State DRAIN: emit words in order row 0..BEATS-1. Within a row: core 0 word 0, core 0 word 1, core 1 word 0, and so on up to core LANES/2-1 word 1.
  - m_data is the stored 60-bit word unchanged.
  - First m_valid rises on the 2nd rising edge after the edge that stored the final beat.
  - With m_ready held high: one word per cycle, no bubbles, including across row boundaries. The next row is prefetched while the current row is serialized.
  - m_valid=1 and m_ready=0: m_data, m_last and m_valid hold stable.
  - m_valid never drops until its word is accepted.
  - On acceptance of the word with m_last=1, go to IDLE the same edge; m_valid=0 the next cycle.
- output_active=1 while in DRAIN: beat dropped, overflow set to 1. Overflow is cleared only by reset.
- Reset mid-frame: the partial frame is discarded and m_valid falls asynchronously.
- busy = (state != IDLE).
- A frame is exactly 2^(LOG_CORE_COUNT+1+LOG_FRAME_BEATS) words; m_last is asserted once per frame.

Optional Feature:
- NTT_OUTPUT_DRAIN_STATS_EN defined:
  - Adds output `frames_done[15:0]`: +1 on each m_last acceptance, wraps at 65535 to 0.
  - Adds output `drop_cnt[15:0]`: +1 per dropped beat, saturates at 65535.
  - Both reset to 0.
- Not defined: neither port nor its counter exists; all other behaviour is identical.

Decomposition:
- Package `ntt_drain_pkg`:
  - word width 60, coefficient width 30.
  - typedef `ntt_word_t` [59:0].
  - enum `drain_state_t` {IDLE, CAPTURE, DRAIN}.
  - function lanes(log_core_count).
- Sub-module `ntt_drain_row_serializer`: takes a registered row plus a load strobe; produces the lane counter, valid/ready output register and prefetch handshake.
- Top module owns the row RAM (one write port, beat-wide; one read port, registered) and the FSM.

Test Plan:
- Full frame, m_ready=1: 64 consecutive beats, word[c][w] = {30'd0, beat*32+c*2+w}, address_out=beat → 2048 words valued 0..2047 in order. First m_valid 2 cycles after the last beat, zero bubbles, m_last only on word 2047, busy low 1 cycle after.
- Out-of-order beats: address_out sequence 63,62..0 with the same data → output stream identical to the in-order case.
- Backpressure: m_ready toggles 1,0,0,1 pseudo-randomly → each of the 2048 words appears exactly once, data held while stalled, m_last on 2047.
- Overflow: during DRAIN inject 3 beats → overflow=1 and stays 1. Stream unaffected; with the stats macro defined, drop_cnt=3.
- Reset mid-DRAIN after 100 words: m_valid=0 immediately, overflow=0. A new full frame then drains correctly from word 0; frames_done counts only completed frames.
- Gapped capture: insert idle cycles every 5th beat → DRAIN entered only after the 64th beat; output identical to the first scenario.
